// File: rtl/bet_pkg.sv
// Shared definitions for the betting ledger.
//   state_t      : ledger FSM states (OPEN / LOCKED / BROKE)
//   SIDE_*       : wager side encodings as driven from SW[9:8]
//   BAL_MAX      : bankroll ceiling used by the saturating settlement
package bet_pkg;

    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_BROKE  = 2'd2
    } state_t;

    localparam logic [1:0] SIDE_PLAYER  = 2'b00;
    localparam logic [1:0] SIDE_DEALER  = 2'b01;
    localparam logic [1:0] SIDE_TIE     = 2'b10;
    localparam logic [1:0] SIDE_INVALID = 2'b11;

    // 12-bit so it compares directly against the widened settlement sum
    localparam logic [11:0] BAL_MAX = 12'd255;

endpackage

// File: rtl/payout_calc.sv
// Settlement arithmetic for one round (purely combinational).
// Ports:
//   balance     in  [7:0] current bankroll
//   bet         in  [7:0] locked wager
//   side        in  [1:0] locked side (SIDE_*)
//   outcome     in  [1:0] {player_win, dealer_win}; 11 = tie, 00 = loss
//   new_balance out [7:0] settled bankroll, clamped to [0, BAL_MAX]
module payout_calc
    import bet_pkg::*;
#(
    parameter int TIE_MULT = 8
) (
    input  logic [7:0] balance,
    input  logic [7:0] bet,
    input  logic [1:0] side,
    input  logic [1:0] outcome,
    output logic [7:0] new_balance
);

    logic        w_tie, w_pwin, w_dwin;
    logic [11:0] w_bal12, w_bet12, w_tie_pay, w_sum;

    assign w_tie     = (outcome == 2'b11);
    assign w_pwin    = (outcome == 2'b10);
    assign w_dwin    = (outcome == 2'b01);
    assign w_bal12   = {4'd0, balance};
    assign w_bet12   = {4'd0, bet};
    assign w_tie_pay = w_bet12 * 12'(TIE_MULT);

    always_comb begin
        w_sum = w_bal12;
        if ((side == SIDE_PLAYER && w_pwin) || (side == SIDE_DEALER && w_dwin))
            w_sum = w_bal12 + w_bet12;
        else if (side == SIDE_TIE && w_tie)
            w_sum = w_bal12 + w_tie_pay;
        else if ((side == SIDE_PLAYER || side == SIDE_DEALER) && w_tie)
            w_sum = w_bal12;                        // push: stake returned
        else
            w_sum = (w_bet12 > w_bal12) ? 12'd0 : (w_bal12 - w_bet12);
    end

    assign new_balance = (w_sum > BAL_MAX) ? BAL_MAX[7:0] : w_sum[7:0];

endmodule

// File: rtl/bet_ledger.sv
// Bankroll ledger for a baccarat-style round: lock a wager, settle on the
// round outcome, go BROKE when the bankroll hits zero.
// Ports:
//   slow_clock           in   clock, all state on rising edge
//   reset                in   synchronous active-high reset
//   bet_amount[7:0]      in   requested wager
//   bet_side[1:0]        in   SIDE_* encoding
//   bet_confirm          in   one-cycle lock request (OPEN only)
//   result_valid         in   one-cycle outcome strobe (LOCKED only)
//   player_win/dealer_win in  outcome bits, both high = tie
//   betenabled           out  high while OPEN
//   updatebalanceenable  out  one-cycle pulse after a settlement
//   balance[7:0]         out  current bankroll
//   locked_bet[7:0]      out  wager held for the round
//   bet_error            out  one-cycle pulse on a rejected confirm
module bet_ledger
    import bet_pkg::*;
#(
    parameter logic [7:0] INIT_BALANCE = 8'd100,
    parameter int         TIE_MULT     = 8
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic [7:0] bet_amount,
    input  logic [1:0] bet_side,
    input  logic       bet_confirm,
    input  logic       result_valid,
    input  logic       player_win,
    input  logic       dealer_win,
    output logic       betenabled,
    output logic       updatebalanceenable,
    output logic [7:0] balance,
    output logic [7:0] locked_bet,
    output logic       bet_error
);

    state_t     r_state;
    logic [1:0] r_side;
    logic [7:0] r_balance, r_locked;
    logic       r_betenabled, r_upd, r_err;

    logic [7:0] w_new_balance, w_lock_amt;
    logic       w_bet_ok;

    payout_calc #(.TIE_MULT(TIE_MULT)) u_payout (
        .balance     (r_balance),
        .bet         (r_locked),
        .side        (r_side),
        .outcome     ({player_win, dealer_win}),
        .new_balance (w_new_balance)
    );

    assign w_bet_ok   = (bet_side != SIDE_INVALID) && (bet_amount != 8'd0);
    // Never stake more than the bankroll, so a loss cannot underflow.
    assign w_lock_amt = (bet_amount > r_balance) ? r_balance : bet_amount;

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            r_state      <= ST_OPEN;
            r_side       <= SIDE_PLAYER;
            r_balance    <= INIT_BALANCE;
            r_locked     <= 8'd0;
            r_betenabled <= 1'b1;
            r_upd        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_OPEN: begin
                    if (bet_confirm) begin
                        if (w_bet_ok) begin
                            r_locked     <= w_lock_amt;
                            r_side       <= bet_side;
                            r_state      <= ST_LOCKED;
                            r_betenabled <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (result_valid) begin
                        r_balance <= w_new_balance;
                        r_locked  <= 8'd0;
                        r_upd     <= 1'b1;
                        if (w_new_balance == 8'd0) begin
                            r_state      <= ST_BROKE;
                            r_betenabled <= 1'b0;
                        end else begin
                            r_state      <= ST_OPEN;
                            r_betenabled <= 1'b1;
                        end
                    end
                end
                default: ;  // BROKE: frozen until reset
            endcase
        end
    end

    assign betenabled          = r_betenabled;
    assign updatebalanceenable = r_upd;
    assign balance             = r_balance;
    assign locked_bet          = r_locked;
    assign bet_error           = r_err;

endmodule

// File: tb/tb_bet_ledger.sv
module tb_bet_ledger;

    logic       slow_clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bet_amount = 8'd0;
    logic [1:0] bet_side = 2'b00;
    logic       bet_confirm = 1'b0;
    logic       result_valid = 1'b0;
    logic       player_win = 1'b0;
    logic       dealer_win = 1'b0;
    logic       betenabled, updatebalanceenable, bet_error;
    logic [7:0] balance, locked_bet;

    bet_ledger #(.INIT_BALANCE(8'd100), .TIE_MULT(8)) dut (
        .slow_clock          (slow_clock),
        .reset               (reset),
        .bet_amount          (bet_amount),
        .bet_side            (bet_side),
        .bet_confirm         (bet_confirm),
        .result_valid        (result_valid),
        .player_win          (player_win),
        .dealer_win          (dealer_win),
        .betenabled          (betenabled),
        .updatebalanceenable (updatebalanceenable),
        .balance             (balance),
        .locked_bet          (locked_bet),
        .bet_error           (bet_error)
    );

    always #5 slow_clock = ~slow_clock;

    typedef struct {
        bit is_err;
        int bal;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Monitor: every pulse must match the next expected event in order.
    always @(negedge slow_clock) begin
        if (updatebalanceenable === 1'b1 && bet_error === 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL pulse_excl: upd and err both high at %0t", $time);
        end else if (updatebalanceenable === 1'b1 || bet_error === 1'b1) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: upd=%0b err=%0b bal=%0d, none expected at %0t",
                         updatebalanceenable, bet_error, balance, $time);
            end else begin
                m_e = q.pop_front();
                if (m_e.is_err != bet_error || m_e.bal != int'(balance)) begin
                    miscompares++;
                    $display("FAIL pulse_event: got err=%0b bal=%0d, expected err=%0b bal=%0d at %0t",
                             bet_error, balance, m_e.is_err, m_e.bal, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_err, input int bal);
        exp_t e;
        e.is_err = is_err;
        e.bal    = bal;
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic confirm(input logic [7:0] amt, input logic [1:0] side);
        bet_amount  = amt;
        bet_side    = side;
        bet_confirm = 1'b1;
        tick();
        bet_confirm = 1'b0;
    endtask

    task automatic result(input logic pw, input logic dw);
        player_win   = pw;
        dealer_win   = dw;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        player_win   = 1'b0;
        dealer_win   = 1'b0;
    endtask

    initial begin
        // reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_balance", balance, 100);
        chk("rst_betenabled", betenabled, 1);
        chk("rst_locked", locked_bet, 0);

        // player bet wins: 100 + 20
        confirm(8'd20, 2'b00);
        chk("p_locked", locked_bet, 20);
        chk("p_betenabled_locked", betenabled, 0);
        push_exp(1'b0, 120);
        result(1'b1, 1'b0);
        chk("p_balance", balance, 120);
        chk("p_upd_high", updatebalanceenable, 1);
        chk("p_betenabled_open", betenabled, 1);
        chk("p_locked_clear", locked_bet, 0);
        tick();
        chk("p_upd_one_cycle", updatebalanceenable, 0);

        // tie bet on tie: 100 + 240 saturates to 255
        do_reset();
        confirm(8'd30, 2'b10);
        push_exp(1'b0, 255);
        result(1'b1, 1'b1);
        chk("tie_saturate", balance, 255);

        // player bet on tie is a push, pulse still issued
        do_reset();
        confirm(8'd40, 2'b00);
        push_exp(1'b0, 100);
        result(1'b1, 1'b1);
        chk("push_balance", balance, 100);

        // no win bits = loss: 100 - 10
        confirm(8'd10, 2'b01);
        push_exp(1'b0, 90);
        result(1'b0, 1'b0);
        chk("nowin_loss", balance, 90);

        // tie bet, player wins: 90 - 5
        confirm(8'd5, 2'b10);
        push_exp(1'b0, 85);
        result(1'b1, 1'b0);
        chk("tie_bet_loss", balance, 85);

        // over-bet clamps to bankroll, loss goes BROKE
        do_reset();
        confirm(8'd200, 2'b00);
        chk("clamp_locked", locked_bet, 100);
        push_exp(1'b0, 0);
        result(1'b0, 1'b1);
        chk("broke_balance", balance, 0);
        chk("broke_betenabled", betenabled, 0);
        confirm(8'd10, 2'b00);
        chk("broke_confirm_ign", locked_bet, 0);
        result(1'b1, 1'b0);
        chk("broke_result_ign", balance, 0);
        tick();
        chk("broke_still_off", betenabled, 0);

        // rejected confirms, result in OPEN ignored
        do_reset();
        push_exp(1'b1, 100);
        confirm(8'd10, 2'b11);
        chk("err_side_betenabled", betenabled, 1);
        chk("err_side_locked", locked_bet, 0);
        chk("err_side_pulse", bet_error, 1);
        tick();
        chk("err_one_cycle", bet_error, 0);
        push_exp(1'b1, 100);
        confirm(8'd0, 2'b00);
        chk("err_zero_locked", locked_bet, 0);
        result(1'b1, 1'b0);
        chk("open_result_ign", balance, 100);
        chk("open_result_nopulse", updatebalanceenable, 0);

        // simultaneous confirm+result: only the state-legal one acts
        bet_amount = 8'd50; bet_side = 2'b01; bet_confirm = 1'b1;
        result(1'b0, 1'b1);
        bet_confirm = 1'b0;
        chk("both_open_locked", locked_bet, 50);
        chk("both_open_balance", balance, 100);
        confirm(8'd7, 2'b00);
        chk("locked_confirm_ign", locked_bet, 50);
        bet_amount = 8'd7; bet_side = 2'b00; bet_confirm = 1'b1;
        push_exp(1'b0, 150);
        result(1'b0, 1'b1);
        bet_confirm = 1'b0;
        chk("both_locked_balance", balance, 150);
        chk("both_locked_clear", locked_bet, 0);

        // reset mid-LOCKED discards the wager
        do_reset();
        confirm(8'd50, 2'b01);
        chk("mid_locked", locked_bet, 50);
        do_reset();
        chk("mid_rst_balance", balance, 100);
        chk("mid_rst_betenabled", betenabled, 1);
        chk("mid_rst_locked", locked_bet, 0);
        chk("mid_rst_nopulse", updatebalanceenable, 0);
        tick(); tick();

        chk("queue_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bet_ledger.md
BET_LEDGER -- requirements
Module: bet_ledger

Interface
- REQ-001 SHALL have parameter INIT_BALANCE, default 8'd100: balance loaded on reset.
- REQ-002 SHALL have parameter TIE_MULT, default 8: tie payout multiplier.
- REQ-003 SHALL have port slow_clock, input, 1: sole clock; all state changes on its rising edge.
- REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
- REQ-005 SHALL have port bet_amount, input, 8: requested wager, driven from SW[7:0] at top level.
- REQ-006 SHALL have port bet_side, input, 2: 00 player, 01 dealer, 10 tie, 11 invalid; driven from SW[9:8].
- REQ-007 SHALL have port bet_confirm, input, 1: one-cycle request to lock the wager.
- REQ-008 SHALL have port result_valid, input, 1: one-cycle strobe; round outcome is valid.
- REQ-009 SHALL have port player_win, input, 1: outcome bit, qualified by result_valid.
- REQ-010 SHALL have port dealer_win, input, 1: outcome bit; both high means tie.
- REQ-011 SHALL have port betenabled, output, 1: high only in state OPEN.
- REQ-012 SHALL have port updatebalanceenable, output, 1: one-cycle pulse when balance is rewritten.
- REQ-013 SHALL have port balance, output, 8: current bankroll.
- REQ-014 SHALL have port locked_bet, output, 8: wager held for the current round.
- REQ-015 SHALL have port bet_error, output, 1: one-cycle pulse on a rejected confirm.

Function
- REQ-016 SHALL implement states OPEN, LOCKED and BROKE.
- REQ-017 In OPEN, bet_confirm with a valid side and nonzero amount SHALL latch locked_bet = min(bet_amount, balance) and the side, and SHALL enter LOCKED next cycle.
- REQ-018 In OPEN, bet_confirm with side 11 or amount 0 SHALL pulse bet_error for one cycle, and state SHALL remain OPEN.
- REQ-019 In LOCKED, result_valid SHALL settle on the same edge, with updatebalanceenable high the following cycle (latency 1).
- REQ-020 A win SHALL add locked_bet for player or dealer sides, or TIE_MULT*locked_bet for the tie side on a tie.
- REQ-021 A player or dealer bet on a tie SHALL be a push: balance unchanged, pulse still issued.
- REQ-022 Any other outcome SHALL subtract locked_bet.
- REQ-023 Settlement arithmetic SHALL be 12-bit unsigned, saturating at 255 and floored at 0.
- REQ-024 result_valid with both win bits low SHALL be treated as a loss.
- REQ-025 After settlement, state SHALL go to BROKE if the new balance is 0, else OPEN, and locked_bet SHALL clear to 0.
- REQ-026 In BROKE, betenabled SHALL be 0 and all inputs SHALL be ignored until reset.
- REQ-027 result_valid in OPEN or BROKE, and bet_confirm in LOCKED, SHALL be ignored with no pulse.
- REQ-028 When bet_confirm and result_valid are asserted together, only the input legal in the current state SHALL act.
- REQ-029 bet_error and updatebalanceenable SHALL never assert in the same cycle.

Reset
- REQ-030 Reset SHALL take priority over all inputs.
- REQ-031 On reset: state OPEN, balance = INIT_BALANCE, locked_bet = 0, betenabled = 1, updatebalanceenable = 0, bet_error = 0.
- REQ-032 Reset mid-LOCKED SHALL discard the wager without settlement.

Structure
- REQ-033 Package bet_pkg SHALL hold the state enum, side encodings (SIDE_PLAYER, SIDE_DEALER, SIDE_TIE, SIDE_INVALID), and the BAL_MAX = 255 constant.
- REQ-034 Combinational sub-module payout_calc (inputs: balance, bet, side, outcome; output: new saturated balance) SHALL isolate settlement arithmetic.
- REQ-035 All outputs SHALL be registered.

Verification
- REQ-036 Reset with INIT_BALANCE 100 -> balance 100, betenabled 1, locked_bet 0.
- REQ-037 Bet 20 player, confirm, result player_win -> balance 120, updatebalanceenable high exactly one cycle, state OPEN.
- REQ-038 Bet 30 tie, tie result -> 100 + 240 = 340, saturates to balance 255.
- REQ-039 Bet 200 player at balance 100 -> locked_bet 100; dealer_win -> balance 0, BROKE, betenabled 0; further confirm ignored.
- REQ-040 Confirm with side 11 -> bet_error pulse, state OPEN; result_valid in OPEN -> balance unchanged, no pulse.
- REQ-041 Bet 50 dealer, reset asserted while LOCKED -> balance 100, OPEN, no update pulse.
